// File: rtl/fir_decim_fifo_if.sv
// Sample/handshake bundle between the FIR, the decimating output stage and the downstream consumer.
// The bench or upstream logic takes the master modport; fir_decim_fifo takes the slave modport.
interface fir_decim_fifo_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int DEPTH  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] din;
  logic              din_en;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready;
  logic [LW-1:0]     level;
  logic              overflow;
  logic              clr_ovf;

  modport master (
    output din, din_en, dout_ready, clr_ovf,
    input  dout, dout_valid, level, overflow
  );

  modport slave (
    input  din, din_en, dout_ready, clr_ovf,
    output dout, dout_valid, level, overflow
  );
endinterface

// File: rtl/fir_decim_fifo.sv
// FIR output stage: keeps 1 of DECIM qualified samples, rounds and saturates to OUT_W bits,
// and buffers the result in a first-word-fall-through FIFO with a sticky overflow flag.
module fir_decim_fifo #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 16,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 8
) (
  input logic            fclk,
  input logic            reset,
  fir_decim_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic signed [DATA_W:0] RND    = (DATA_W+1)'(1) << (SHIFT-1);
  localparam logic signed [DATA_W:0] SAT_HI = ((DATA_W+1)'(1) << (OUT_W-1)) - (DATA_W+1)'(1);
  localparam logic signed [DATA_W:0] SAT_LO = ~SAT_HI;

  logic [PW-1:0]           phase;
  logic                    keep;
  logic signed [DATA_W:0]  t;
  logic signed [DATA_W:0]  r;
  logic [OUT_W-1:0]        conv_nxt;
  logic [OUT_W-1:0]        conv_data;
  logic                    conv_vld;

  logic [OUT_W-1:0]        mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic                    full;
  logic                    empty;
  logic                    rd;
  logic                    wr;
  logic                    drop;
  logic                    overflow;

  assign keep = bus.din_en && (phase == '0);

  // Phase only moves on qualified samples, so din_en gaps don't skew the decimation grid.
  always_ff @(posedge fclk) begin
    if (!reset)
      phase <= '0;
    else if (bus.din_en)
      phase <= (phase == PW'(DECIM-1)) ? '0 : phase + PW'(1);
  end

  // Sign-extend one bit so adding the half-LSB can never wrap.
  always_comb begin
    t = $signed({bus.din[DATA_W-1], bus.din}) + RND;
    r = t >>> SHIFT;
    if (r > SAT_HI)
      conv_nxt = SAT_HI[OUT_W-1:0];
    else if (r < SAT_LO)
      conv_nxt = SAT_LO[OUT_W-1:0];
    else
      conv_nxt = r[OUT_W-1:0];
  end

  always_ff @(posedge fclk) begin
    if (!reset) begin
      conv_vld  <= 1'b0;
      conv_data <= '0;
    end else begin
      conv_vld  <= keep;
      if (keep)
        conv_data <= conv_nxt;
    end
  end

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rd    = !empty && bus.dout_ready;
  // A read on the same edge frees the head slot, so a write into a full FIFO is still legal.
  assign wr    = conv_vld && (!full || rd);
  assign drop  = conv_vld && full && !rd;

  always_ff @(posedge fclk) begin
    if (wr)
      mem[wr_ptr] <= conv_data;
  end

  always_ff @(posedge fclk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (bus.clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign bus.dout_valid = !empty;
  assign bus.dout       = empty ? '0 : mem[rd_ptr];
  assign bus.level      = level;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo (DECIM=4, SHIFT=16, OUT_W=16, DEPTH=8).
module tb_fir_decim_fifo;
  logic fclk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  fir_decim_fifo_if #(.DATA_W(32), .OUT_W(16), .DEPTH(8)) bus ();

  fir_decim_fifo #(
    .DATA_W(32), .OUT_W(16), .SHIFT(16), .DECIM(4), .DEPTH(8)
  ) dut (
    .fclk  (fclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 fclk = ~fclk;

  // Outputs are observed 1 time unit after each rising edge; inputs change there too.
  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  // One kept sample followed by three non-kept qualified samples: phase returns to 0.
  task automatic send(input logic [31:0] v);
    bus.din    = v;
    bus.din_en = 1'b1;
    step();
    bus.din = JUNK;
    repeat (3) step();
    bus.din_en = 1'b0;
  endtask

  task automatic pop();
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    checks++; if (bus.level !== 4'd0) $display("FAIL reset_level got %0d exp 0", bus.level); else passed++;
    checks++; if (bus.dout_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.dout_valid); else passed++;
    checks++; if (bus.dout !== 16'h0000) $display("FAIL reset_dout got %h exp 0000", bus.dout); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b exp 0", bus.overflow); else passed++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_decimation();
    logic        ev;
    logic [15:0] ed;
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      bus.din    = (k < 12) ? (32'(k) << 16) : 32'h0;
      bus.din_en = (k < 12);
      step();
      // kept at k=0,4,8: captured on that edge, in the FIFO one edge later, read the edge after
      ev = (k >= 1) && ((k-1) % 4 == 0) && (k-1 <= 8);
      ed = ev ? 16'(k-1) : 16'h0;
      checks++; if (bus.dout_valid !== ev) $display("FAIL dec_valid[%0d] got %b exp %b", k, bus.dout_valid, ev); else passed++;
      checks++; if (bus.dout !== ed) $display("FAIL dec_dout[%0d] got %h exp %h", k, bus.dout, ed); else passed++;
      checks++; if (bus.level > 4'd1) $display("FAIL dec_level[%0d] got %0d exp <=1", k, bus.level); else passed++;
    end
    bus.din_en     = 1'b0;
    bus.dout_ready = 1'b0;
  endtask

  task automatic test_rounding();
    logic [15:0] exp_q [4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    send(32'h0000_8000);
    send(32'h0000_7FFF);
    send(32'hFFFF_8000);
    send(32'hFFFF_7FFF);
    checks++; if (bus.level !== 4'd4) $display("FAIL rnd_level got %0d exp 4", bus.level); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.dout !== exp_q[i]) $display("FAIL rnd_dout[%0d] got %h exp %h", i, bus.dout, exp_q[i]); else passed++;
      pop();
    end
  endtask

  task automatic test_saturation();
    send(32'h7FFF_FFFF);
    send(32'h8000_0000);
    checks++; if (bus.dout !== 16'h7FFF) $display("FAIL sat_hi got %h exp 7fff", bus.dout); else passed++;
    pop();
    checks++; if (bus.dout !== 16'h8000) $display("FAIL sat_lo got %h exp 8000", bus.dout); else passed++;
    pop();
    checks++; if (bus.level !== 4'd0) $display("FAIL sat_level got %0d exp 0", bus.level); else passed++;
  endtask

  task automatic test_full_overflow();
    for (int v = 1; v <= 8; v++) send(32'(v) << 16);
    checks++; if (bus.level !== 4'd8) $display("FAIL full_level8 got %0d exp 8", bus.level); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL full_ovf_pre got %b exp 0", bus.overflow); else passed++;
    send(32'(9) << 16);
    checks++; if (bus.level !== 4'd8) $display("FAIL full_level9 got %0d exp 8", bus.level); else passed++;
    checks++; if (bus.overflow !== 1'b1) $display("FAIL full_ovf_set got %b exp 1", bus.overflow); else passed++;
    for (int v = 1; v <= 8; v++) begin
      checks++; if (bus.dout !== 16'(v)) $display("FAIL full_drain[%0d] got %h exp %h", v, bus.dout, 16'(v)); else passed++;
      pop();
    end
    checks++; if (bus.level !== 4'd0) $display("FAIL full_empty got %0d exp 0", bus.level); else passed++;
    checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.overflow); else passed++;
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", bus.overflow); else passed++;
  endtask

  task automatic test_rw_at_full();
    for (int v = 10; v <= 17; v++) send(32'(v) << 16);
    checks++; if (bus.level !== 4'd8) $display("FAIL rw_fill got %0d exp 8", bus.level); else passed++;
    bus.din    = 32'(18) << 16;
    bus.din_en = 1'b1;
    step();
    bus.din        = JUNK;
    bus.dout_ready = 1'b1;
    step();
    bus.dout_ready = 1'b0;
    repeat (2) step();
    bus.din_en = 1'b0;
    checks++; if (bus.level !== 4'd8) $display("FAIL rw_level got %0d exp 8", bus.level); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL rw_ovf got %b exp 0", bus.overflow); else passed++;
    for (int v = 11; v <= 18; v++) begin
      checks++; if (bus.dout !== 16'(v)) $display("FAIL rw_drain[%0d] got %h exp %h", v, bus.dout, 16'(v)); else passed++;
      pop();
    end
    checks++; if (bus.dout_valid !== 1'b0) $display("FAIL rw_empty got %b exp 0", bus.dout_valid); else passed++;
  endtask

  task automatic test_stall_reset();
    for (int v = 21; v <= 29; v++) send(32'(v) << 16);
    repeat (4) pop();
    // kept sample moves phase to 1, then din_en stays low for 10 clocks
    bus.din    = 32'(30) << 16;
    bus.din_en = 1'b1;
    step();
    bus.din_en = 1'b0;
    repeat (10) step();
    checks++; if (bus.level !== 4'd5) $display("FAIL stall_level got %0d exp 5", bus.level); else passed++;
    checks++; if (bus.overflow !== 1'b1) $display("FAIL stall_ovf got %b exp 1", bus.overflow); else passed++;
    checks++; if (bus.dout !== 16'd25) $display("FAIL stall_head got %h exp 0019", bus.dout); else passed++;
    // phases 1 and 2 are not kept if the phase held through the stall
    bus.din    = JUNK;
    bus.din_en = 1'b1;
    repeat (2) step();
    bus.din_en = 1'b0;
    repeat (2) step();
    checks++; if (bus.level !== 4'd5) $display("FAIL phase_hold got %0d exp 5", bus.level); else passed++;
    reset = 1'b0;
    step();
    checks++; if (bus.level !== 4'd0) $display("FAIL mreset_level got %0d exp 0", bus.level); else passed++;
    checks++; if (bus.dout_valid !== 1'b0) $display("FAIL mreset_valid got %b exp 0", bus.dout_valid); else passed++;
    checks++; if (bus.dout !== 16'h0000) $display("FAIL mreset_dout got %h exp 0000", bus.dout); else passed++;
    checks++; if (bus.overflow !== 1'b0) $display("FAIL mreset_ovf got %b exp 0", bus.overflow); else passed++;
    reset      = 1'b1;
    bus.din    = 32'h0005_0000;
    bus.din_en = 1'b1;
    step();
    bus.din_en = 1'b0;
    step();
    checks++; if (bus.level !== 4'd1) $display("FAIL post_reset_level got %0d exp 1", bus.level); else passed++;
    checks++; if (bus.dout !== 16'h0005) $display("FAIL post_reset_dout got %h exp 0005", bus.dout); else passed++;
  endtask

  initial begin
    reset          = 1'b0;
    bus.din        = '0;
    bus.din_en     = 1'b0;
    bus.dout_ready = 1'b0;
    bus.clr_ovf    = 1'b0;
    test_reset();
    test_decimation();
    test_rounding();
    test_saturation();
    test_full_overflow();
    test_rw_at_full();
    test_stall_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
